// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//   Bundles the upstream and downstream sides of one inter-stage pipeline
//   register (valid/ready handshake plus the PC/instruction/data/exception/
//   branch-delay payload).
//
// Parameters:
//   DATA_LANES  number of 32-bit data lanes (1..8)
//   EXC_W       exception-code width
//
// Signals:
//   in_valid, in_ready                         upstream handshake
//   pc_i, instr_i, data_i, exc_i, bd_i         upstream payload
//   out_valid, out_ready                       downstream handshake
//   pc_o, instr_o, data_o, exc_o, bd_o         registered payload
//
// Modports:
//   slave   the pipeline register itself
//   master  the surrounding stages (drives upstream payload, consumes output)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_LANES = 3,
    parameter int EXC_W      = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic [31:0]                pc_i;
    logic [31:0]                instr_i;
    logic [32*DATA_LANES-1:0]   data_i;
    logic [EXC_W-1:0]           exc_i;
    logic                       bd_i;

    logic                       out_valid;
    logic                       out_ready;
    logic [31:0]                pc_o;
    logic [31:0]                instr_o;
    logic [32*DATA_LANES-1:0]   data_o;
    logic [EXC_W-1:0]           exc_o;
    logic                       bd_o;

    modport slave (
        input  in_valid, pc_i, instr_i, data_i, exc_i, bd_i, out_ready,
        output in_ready, out_valid, pc_o, instr_o, data_o, exc_o, bd_o
    );

    modport master (
        output in_valid, pc_i, instr_i, data_i, exc_i, bd_i, out_ready,
        input  in_ready, out_valid, pc_o, instr_o, data_o, exc_o, bd_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register for the five-stage MIPS core (D/E, E/M,
//   M/W). Holds PC, instruction, DATA_LANES 32-bit data lanes, exception code
//   and branch-delay flag behind a valid/ready handshake.
//
//   - req   : drop everything, present HANDLER_PC with a NOP payload.
//   - flush : drop everything, present pc_i with a NOP payload.
//   - When the entry is consumed with nothing to replace it, the payload
//     becomes a NOP and pc_o holds, so consumers ignoring out_valid see a NOP.
//   Priority: reset > req > flush > handshake.
//
// Configuration macro PIPE_STAGE_SKID_EN:
//   defined   : one-entry skid buffer, in_ready = ~skid_valid (registered,
//               no combinational path from out_ready).
//   undefined : single register, in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk    clock, all state updates on posedge
//   reset  asynchronous, active-high
//   req    exception request (flush + load HANDLER_PC)
//   flush  bubble flush (eret, mispredict)
//   bus    pipe_stage_reg_if.slave, handshake and payload
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int          DATA_LANES = 3,
    parameter int          EXC_W      = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    pipe_stage_reg_if.slave   bus
);

    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              instr;
        logic [32*DATA_LANES-1:0] data;
        logic [EXC_W-1:0]         exc;
        logic                     bd;
    } entry_t;

    // NOP payload carrying a given PC.
    function automatic entry_t make_bubble(input logic [31:0] pc);
        entry_t e;
        e    = '0;
        e.pc = pc;
        return e;
    endfunction

    entry_t in_entry;
    entry_t main_q, main_d;
    logic   main_valid_q, main_valid_d;
    logic   in_ready;
    logic   accept;
    logic   consume;

    assign in_entry = '{pc:    bus.pc_i,
                        instr: bus.instr_i,
                        data:  bus.data_i,
                        exc:   bus.exc_i,
                        bd:    bus.bd_i};

    assign accept  = bus.in_valid & in_ready;
    assign consume = main_valid_q & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    // Skid occupancy is a flop, so in_ready never sees out_ready directly.
    assign in_ready = ~skid_valid_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (!main_valid_q) begin
            // Skid can only be occupied while main is full.
            if (accept) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end
        end else if (consume) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_d       = '0;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_entry;
            end else begin
                main_d       = make_bubble(main_q.pc);
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end

        if (req) begin
            main_d       = make_bubble(HANDLER_PC);
            main_valid_d = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end else if (flush) begin
            main_d       = make_bubble(bus.pc_i);
            main_valid_d = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the skid payload is a single entry, so it is reset with
            // the rest rather than left uninitialised like a RAM.
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    // Ready whenever the register is empty or is being drained this cycle.
    assign in_ready = ~main_valid_q | bus.out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;

        if (accept) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
        end else if (consume) begin
            main_d       = make_bubble(main_q.pc);
            main_valid_d = 1'b0;
        end

        if (req) begin
            main_d       = make_bubble(HANDLER_PC);
            main_valid_d = 1'b0;
        end else if (flush) begin
            main_d       = make_bubble(bus.pc_i);
            main_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            main_q       <= make_bubble(RESET_PC);
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid_q;
    assign bus.pc_o      = main_q.pc;
    assign bus.instr_o   = main_q.instr;
    assign bus.data_o    = main_q.data;
    assign bus.exc_o     = main_q.exc;
    assign bus.bd_o      = main_q.bd;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Self-checking bench for pipe_stage_reg. The reference model is an ordered
//   queue of entries (capacity 2 with the skid buffer, 1 without) plus the PC
//   shown while empty. Inputs change on the falling edge; outputs are sampled
//   1 time unit after it.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int          DL  = 3;
    localparam int          EW  = 5;
    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam logic [31:0] HPC = 32'h0000_4180;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [32*DL-1:0] data;
        logic [EW-1:0]    exc;
        logic             bd;
    } ent_t;

    logic clk;
    logic reset;
    logic req;
    logic flush;

    pipe_stage_reg_if #(.DATA_LANES(DL), .EXC_W(EW)) bus ();

    pipe_stage_reg #(
        .DATA_LANES(DL),
        .EXC_W     (EW),
        .RESET_PC  (RPC),
        .HANDLER_PC(HPC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    logic [31:0] shown_pc;
    logic [31:0] pc_ctr;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t rand_entry(input logic [31:0] pc, input logic force_exc4);
        ent_t e;
        e.pc    = pc;
        e.instr = $urandom;
        for (int k = 0; k < DL; k++) e.data[k*32 +: 32] = $urandom;
        if (force_exc4)                  e.exc = 5'd4;
        else if ($urandom_range(0, 3) == 0) e.exc = EW'($urandom);
        else                             e.exc = '0;
        e.bd = 1'($urandom);
        return e;
    endfunction

    task automatic drive(input logic v, input logic r, input ent_t e,
                         input logic rq, input logic fl);
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.pc_i      = e.pc;
        bus.instr_i   = e.instr;
        bus.data_i    = e.data;
        bus.exc_i     = e.exc;
        bus.bd_i      = e.bd;
        req           = rq;
        flush         = fl;
    endtask

    function automatic logic model_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || bus.out_ready;
`endif
    endfunction

    task automatic check_outputs();
        ent_t exp_e;
        logic exp_v;
        if (q.size() > 0) begin
            exp_e = q[0];
            exp_v = 1'b1;
        end else begin
            exp_e    = '0;
            exp_e.pc = shown_pc;
            exp_v    = 1'b0;
        end
        check("out_valid", 256'(bus.out_valid), 256'(exp_v));
        check("pc_o",      256'(bus.pc_o),      256'(exp_e.pc));
        check("instr_o",   256'(bus.instr_o),   256'(exp_e.instr));
        check("data_o",    256'(bus.data_o),    256'(exp_e.data));
        check("exc_o",     256'(bus.exc_o),     256'(exp_e.exc));
        check("bd_o",      256'(bus.bd_o),      256'(exp_e.bd));
        check("in_ready",  256'(bus.in_ready),  256'(model_ready()));
    endtask

    // One clock cycle: check, advance the model across the edge, return at
    // the next falling edge ready for new inputs.
    task automatic step();
        ent_t cur;
        logic acc, con;
        #1;
        check_outputs();
        acc = bus.in_valid && model_ready();
        con = (q.size() > 0) && bus.out_ready;
        cur = '{pc: bus.pc_i, instr: bus.instr_i, data: bus.data_i,
                exc: bus.exc_i, bd: bus.bd_i};
        @(posedge clk);
        if (req) begin
            q.delete();
            shown_pc = HPC;
        end else if (flush) begin
            q.delete();
            shown_pc = cur.pc;
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(cur);
            if (q.size() > 0) shown_pc = q[0].pc;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        drive(1'b0, r, rand_entry(32'h0, 1'b0), 1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        q.delete();
        shown_pc = RPC;
        pc_ctr   = RPC;
        idle(1'b0);

        // Reset values, then held through a clock edge.
        @(negedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Stream four entries with out_ready high.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, rand_entry(RPC + 32'(4*i), 1'b0), 1'b0, 1'b0);
            step();
        end
        pc_ctr = RPC + 32'h10;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            step();
        end

        // Backpressure while streaming.
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  rand_entry(pc_ctr, 1'b0), 1'b0, 1'b0);
            pc_ctr += 4;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            step();
        end

        // Fill with exc=4 entries under backpressure, then req.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, rand_entry(pc_ctr, 1'b1), 1'b0, 1'b0);
            pc_ctr += 4;
            step();
        end
        drive(1'b1, 1'b1, rand_entry(pc_ctr, 1'b1), 1'b1, 1'b0);
        step();
        idle(1'b0);
        step();

        // Flush with pc_i = 0x3020, then a normal entry.
        drive(1'b1, 1'b1, rand_entry(32'h0000_3000, 1'b0), 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, rand_entry(32'h0000_3020, 1'b0), 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b1, rand_entry(32'h0000_3024, 1'b0), 1'b0, 1'b0);
        step();
        idle(1'b1);
        step();
        step();

        // Random mix including occasional req and flush.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  rand_entry(pc_ctr, 1'b0),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
            pc_ctr += 4;
            step();
        end

        // Asynchronous reset mid-transfer, checked before any clock edge.
        drive(1'b1, 1'b0, rand_entry(pc_ctr, 1'b0), 1'b0, 1'b0);
        step();
        step();
        #2;
        reset = 1'b1;
        q.delete();
        shown_pc = RPC;
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        idle(1'b1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
